// File: rtl/ghost_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : ghost_pkg
//  Purpose  : Shared types and constants for the ghost move scheduler:
//             direction codes, ghost indices, tile width, FSM encoding.
//  Revision : 1.0  initial release
// ============================================================================
package ghost_pkg;

  localparam int TILE_W = 9;

  // Direction unit result codes; 2'b11 is treated as no move like 2'b00
  localparam logic [1:0] DIR_NONE = 2'b00;
  localparam logic [1:0] DIR_POS  = 2'b01;
  localparam logic [1:0] DIR_NEG  = 2'b10;

  localparam logic [1:0] GHOST_RED   = 2'd0;
  localparam logic [1:0] GHOST_BLUE  = 2'd1;
  localparam logic [1:0] GHOST_GREEN = 2'd2;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ISSUE   = 3'd1,
    ST_WAIT    = 3'd2,
    ST_PROBE_X = 3'd3,
    ST_PROBE_Y = 3'd4,
    ST_COMMIT  = 3'd5,
    ST_DONE    = 3'd6
  } state_e;

  // Frightened mode swaps +1 and -1; anything else stays a no-move
  function automatic logic [1:0] dir_invert(input logic [1:0] d);
    case (d)
      DIR_POS: dir_invert = DIR_NEG;
      DIR_NEG: dir_invert = DIR_POS;
      default: dir_invert = DIR_NONE;
    endcase
  endfunction

endpackage : ghost_pkg
`default_nettype wire

// File: rtl/ghost_step_calc.sv
`default_nettype none
// ============================================================================
//  Module   : ghost_step_calc
//  Purpose  : Combinational single-axis step: given a tile coordinate and a
//             direction code, produce the candidate coordinate and flag a
//             step that would leave the maze [0, max_i].
//  Revision : 1.0  initial release
// ============================================================================
module ghost_step_calc
  import ghost_pkg::*;
(
  input  logic [TILE_W-1:0] pos_i,
  input  logic [1:0]        dir_i,
  input  logic [TILE_W-1:0] max_i,
  output logic [TILE_W-1:0] cand_o,
  output logic              move_o,
  output logic              oob_o
);

  // Decode the direction and form the neighbouring coordinate on this axis
  always_comb begin
    cand_o = pos_i;
    move_o = 1'b0;
    oob_o  = 1'b0;
    if (dir_i == DIR_POS) begin
      move_o = 1'b1;
      cand_o = pos_i + {{(TILE_W-1){1'b0}}, 1'b1};
      oob_o  = (pos_i == max_i);
    end else if (dir_i == DIR_NEG) begin
      move_o = 1'b1;
      cand_o = pos_i - {{(TILE_W-1){1'b0}}, 1'b1};
      oob_o  = (pos_i == '0);
    end
  end

endmodule : ghost_step_calc
`default_nettype wire

// File: rtl/ghost_move_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : ghost_move_scheduler
//  Purpose  : Per-frame sequencer for the three ghosts. Each tick it shares
//             one pipelined direction unit and one maze lookup port across
//             ghosts 0,1,2 and commits at most one legal step per ghost.
//  Revision : 1.0  initial release
// ============================================================================
module ghost_move_scheduler
  import ghost_pkg::*;
#(
  parameter int                DIR_LAT = 2,
  parameter logic [TILE_W-1:0] MAP_MAX = 9'd20,
  parameter logic [TILE_W-1:0] HOME0_X = 9'd10,
  parameter logic [TILE_W-1:0] HOME0_Y = 9'd9,
  parameter logic [TILE_W-1:0] HOME1_X = 9'd9,
  parameter logic [TILE_W-1:0] HOME1_Y = 9'd10,
  parameter logic [TILE_W-1:0] HOME2_X = 9'd11,
  parameter logic [TILE_W-1:0] HOME2_Y = 9'd10
) (
  input  logic              clock_in,
  input  logic              reset_n,
  input  logic              tick,
  input  logic              frightened,
  input  logic [TILE_W-1:0] pacman_x,
  input  logic [TILE_W-1:0] pacman_y,
  output logic              dir_req,
  output logic [TILE_W-1:0] dir_gx,
  output logic [TILE_W-1:0] dir_gy,
  output logic [TILE_W-1:0] dir_tx,
  output logic [TILE_W-1:0] dir_ty,
  input  logic [1:0]        dir_dx,
  input  logic [1:0]        dir_dy,
  output logic              map_req,
  output logic [TILE_W-1:0] map_x,
  output logic [TILE_W-1:0] map_y,
  input  logic              map_ack,
  input  logic              map_wall,
  output logic [TILE_W-1:0] g0_x,
  output logic [TILE_W-1:0] g0_y,
  output logic [TILE_W-1:0] g1_x,
  output logic [TILE_W-1:0] g1_y,
  output logic [TILE_W-1:0] g2_x,
  output logic [TILE_W-1:0] g2_y,
  output logic              busy,
  output logic              round_done,
  output logic [2:0]        hit,
  output logic              overrun
);

  localparam int CNT_W = 4;

  state_e            state_q, state_d;
  logic [1:0]        idx_q, idx_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [TILE_W-1:0] px_q, px_d, py_q, py_d;
  logic              fr_q, fr_d;
  logic [1:0]        dx_q, dx_d, dy_q, dy_d;
  logic [TILE_W-1:0] nx_q, nx_d, ny_q, ny_d;
  logic              pend_q, pend_d;
  logic              ovr_q, ovr_d;
  logic [TILE_W-1:0] gx_q [0:2];
  logic [TILE_W-1:0] gy_q [0:2];
  logic [TILE_W-1:0] gx_d [0:2];
  logic [TILE_W-1:0] gy_d [0:2];

  logic [TILE_W-1:0] cur_x, cur_y, x_cand, y_cand;
  logic              x_move, x_oob, y_move, y_oob;

  assign cur_x = gx_q[idx_q];
  assign cur_y = gy_q[idx_q];

  ghost_step_calc u_step_x (
    .pos_i  (cur_x),
    .dir_i  (dx_q),
    .max_i  (MAP_MAX),
    .cand_o (x_cand),
    .move_o (x_move),
    .oob_o  (x_oob)
  );

  ghost_step_calc u_step_y (
    .pos_i  (cur_y),
    .dir_i  (dy_q),
    .max_i  (MAP_MAX),
    .cand_o (y_cand),
    .move_o (y_move),
    .oob_o  (y_oob)
  );

  assign dir_gx  = cur_x;
  assign dir_gy  = cur_y;
  assign dir_tx  = px_q;
  assign dir_ty  = py_q;
  assign g0_x    = gx_q[0];
  assign g0_y    = gy_q[0];
  assign g1_x    = gx_q[1];
  assign g1_y    = gy_q[1];
  assign g2_x    = gx_q[2];
  assign g2_y    = gy_q[2];
  assign busy    = (state_q != ST_IDLE) && (state_q != ST_DONE);
  assign overrun = ovr_q;

  // Next-state logic and request/pulse outputs for the round sequencer
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    cnt_d      = cnt_q;
    px_d       = px_q;
    py_d       = py_q;
    fr_d       = fr_q;
    dx_d       = dx_q;
    dy_d       = dy_q;
    nx_d       = nx_q;
    ny_d       = ny_q;
    pend_d     = pend_q;
    ovr_d      = ovr_q;
    gx_d       = gx_q;
    gy_d       = gy_q;
    dir_req    = 1'b0;
    map_req    = 1'b0;
    map_x      = cur_x;
    map_y      = cur_y;
    hit        = 3'b000;
    round_done = 1'b0;

    // Any tick outside IDLE (DONE included) is queued one deep
    if (state_q != ST_IDLE && tick) begin
      if (pend_q) ovr_d = 1'b1;
      else        pend_d = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (tick || pend_q) begin
          state_d = ST_ISSUE;
          idx_d   = GHOST_RED;
          px_d    = pacman_x;
          py_d    = pacman_y;
          fr_d    = frightened;
          // One request is consumed; a coincident second one stays queued
          pend_d  = tick & pend_q;
        end
      end
      ST_ISSUE: begin
        dir_req = 1'b1;
        cnt_d   = CNT_W'(DIR_LAT);
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        cnt_d = cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
        if (cnt_q == {{(CNT_W-1){1'b0}}, 1'b1}) begin
          dx_d    = fr_q ? dir_invert(dir_dx) : dir_dx;
          dy_d    = fr_q ? dir_invert(dir_dy) : dir_dy;
          nx_d    = cur_x;
          ny_d    = cur_y;
          state_d = ST_PROBE_X;
        end
      end
      ST_PROBE_X: begin
        if (!x_move || x_oob) begin
          state_d = ST_PROBE_Y;
        end else begin
          map_req = 1'b1;
          map_x   = x_cand;
          map_y   = cur_y;
          if (map_ack) begin
            if (!map_wall) begin
              nx_d    = x_cand;
              state_d = ST_COMMIT;
            end else begin
              state_d = ST_PROBE_Y;
            end
          end
        end
      end
      ST_PROBE_Y: begin
        if (!y_move || y_oob) begin
          state_d = ST_COMMIT;
        end else begin
          map_req = 1'b1;
          map_x   = cur_x;
          map_y   = y_cand;
          if (map_ack) begin
            if (!map_wall) ny_d = y_cand;
            state_d = ST_COMMIT;
          end
        end
      end
      ST_COMMIT: begin
        gx_d[idx_q] = nx_q;
        gy_d[idx_q] = ny_q;
        if (nx_q == px_q && ny_q == py_q) hit = 3'b001 << idx_q;
        if (idx_q == GHOST_GREEN) begin
          state_d = ST_DONE;
        end else begin
          idx_d   = idx_q + 2'd1;
          state_d = ST_ISSUE;
        end
      end
      ST_DONE: begin
        round_done = 1'b1;
        state_d    = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers; reset returns every ghost to its home tile
  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      idx_q   <= GHOST_RED;
      cnt_q   <= '0;
      px_q    <= '0;
      py_q    <= '0;
      fr_q    <= 1'b0;
      dx_q    <= DIR_NONE;
      dy_q    <= DIR_NONE;
      nx_q    <= '0;
      ny_q    <= '0;
      pend_q  <= 1'b0;
      ovr_q   <= 1'b0;
      gx_q[0] <= HOME0_X;
      gy_q[0] <= HOME0_Y;
      gx_q[1] <= HOME1_X;
      gy_q[1] <= HOME1_Y;
      gx_q[2] <= HOME2_X;
      gy_q[2] <= HOME2_Y;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      px_q    <= px_d;
      py_q    <= py_d;
      fr_q    <= fr_d;
      dx_q    <= dx_d;
      dy_q    <= dy_d;
      nx_q    <= nx_d;
      ny_q    <= ny_d;
      pend_q  <= pend_d;
      ovr_q   <= ovr_d;
      gx_q    <= gx_d;
      gy_q    <= gy_d;
    end
  end

endmodule : ghost_move_scheduler
`default_nettype wire

// File: tb/tb_ghost_move_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ghost_move_scheduler
//  Purpose  : Self-checking bench for ghost_move_scheduler with a behavioural
//             direction unit, maze ROM responder and round-level model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_ghost_move_scheduler;

  localparam int DIR_LAT = 2;
  localparam int MAXT    = 20;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       tick = 1'b0;
  logic       frightened = 1'b0;
  logic [8:0] pacman_x = '0, pacman_y = '0;
  logic       dir_req;
  logic [8:0] dir_gx, dir_gy, dir_tx, dir_ty;
  logic [1:0] dir_dx = '0, dir_dy = '0;
  logic       map_req;
  logic [8:0] map_x, map_y;
  logic       map_ack = 1'b0, map_wall = 1'b0;
  logic [8:0] g0_x, g0_y, g1_x, g1_y, g2_x, g2_y;
  logic       busy, round_done, overrun;
  logic [2:0] hit;

  ghost_move_scheduler #(.DIR_LAT(DIR_LAT)) dut (
    .clock_in(clk), .reset_n(reset_n), .tick(tick), .frightened(frightened),
    .pacman_x(pacman_x), .pacman_y(pacman_y),
    .dir_req(dir_req), .dir_gx(dir_gx), .dir_gy(dir_gy), .dir_tx(dir_tx), .dir_ty(dir_ty),
    .dir_dx(dir_dx), .dir_dy(dir_dy),
    .map_req(map_req), .map_x(map_x), .map_y(map_y), .map_ack(map_ack), .map_wall(map_wall),
    .g0_x(g0_x), .g0_y(g0_y), .g1_x(g1_x), .g1_y(g1_y), .g2_x(g2_x), .g2_y(g2_y),
    .busy(busy), .round_done(round_done), .hit(hit), .overrun(overrun)
  );

  always #5 clk = ~clk;

  // Environment state shared with the responders
  bit         wall [0:20][0:20];
  logic [1:0] pdx [3];
  logic [1:0] pdy [3];
  bit         ack_hold = 1'b0;

  // Reference model state
  int         mx [3] = '{10, 9, 11};
  int         my [3] = '{9, 10, 10};
  int         ep_x [8];
  int         ep_y [8];
  int         exp_np;
  logic [2:0] exp_hit;

  int tests = 0;
  int fails = 0;

  // Observations from the direction-unit responder / monitor
  int         cyc = 0, rq = 0, dly = 0, dg = 0, done_cnt = 0, done_cyc = 0;
  int         dreq_cyc [3];
  int         hit_cyc [3];
  logic [2:0] hit_word = '0;
  logic [8:0] seen_gx [3];
  logic [8:0] seen_gy [3];
  logic [8:0] seen_tx [3];
  logic [8:0] seen_ty [3];

  // Observations from the maze responder
  int pcount = 0, mdly = 0;
  int plog_x [256];
  int plog_y [256];

  function automatic bit wall_at(input logic [8:0] x, input logic [8:0] y);
    if (x <= 9'd20 && y <= 9'd20) return wall[int'(x)][int'(y)];
    return 1'b1;
  endfunction

  // Direction unit: answers exactly DIR_LAT cycles after each request, noise otherwise
  always @(negedge clk) begin
    if (!reset_n) begin
      rq  = 0;
      dly = 0;
    end else begin
      cyc = cyc + 1;
      if (dly > 0) dly = dly - 1;
      if (dly == 0 && dg >= 0 && cyc > 0 && dreq_cyc[dg] == cyc - DIR_LAT) begin
        dir_dx = pdx[dg];
        dir_dy = pdy[dg];
      end else begin
        dir_dx = 2'($urandom);
        dir_dy = 2'($urandom);
      end
      if (dir_req) begin
        if (rq == 0) hit_word = '0;
        dreq_cyc[rq] = cyc;
        seen_gx[rq]  = dir_gx;
        seen_gy[rq]  = dir_gy;
        seen_tx[rq]  = dir_tx;
        seen_ty[rq]  = dir_ty;
        dg  = rq;
        dly = DIR_LAT;
        rq  = (rq == 2) ? 0 : rq + 1;
      end
      if (hit != 3'b000) begin
        hit_word = hit_word | hit;
        for (int b = 0; b < 3; b++) if (hit[b]) hit_cyc[b] = cyc;
      end
      if (round_done) begin
        done_cyc = cyc;
        done_cnt = done_cnt + 1;
      end
    end
  end

  // Maze ROM: random ack latency, plus stray acks while nothing is requested
  always @(negedge clk) begin
    if (map_ack) begin
      map_ack  = 1'b0;
      map_wall = 1'($urandom);
    end else if (map_req && reset_n && !ack_hold) begin
      if (mdly == 0) begin
        map_ack  = 1'b1;
        map_wall = wall_at(map_x, map_y);
        plog_x[pcount % 256] = int'(map_x);
        plog_y[pcount % 256] = int'(map_y);
        pcount = pcount + 1;
        mdly   = $urandom_range(0, 2);
      end else begin
        mdly = mdly - 1;
      end
    end else if (!map_req && $urandom_range(0, 3) == 0) begin
      map_ack  = 1'b1;
      map_wall = 1'($urandom);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int dec(input logic [1:0] c);
    if (c == 2'b01) return 1;
    if (c == 2'b10) return -1;
    return 0;
  endfunction

  function automatic int gpos(input int g, input bit y);
    case (g)
      0:       return y ? int'(g0_y) : int'(g0_x);
      1:       return y ? int'(g1_y) : int'(g1_x);
      default: return y ? int'(g2_y) : int'(g2_x);
    endcase
  endfunction

  // One round from the rules: try X then Y, edges block without a lookup
  task automatic model_round(input bit fr, input int pxs, input int pys);
    int  sx, sy, c;
    bit  moved;
    exp_np  = 0;
    exp_hit = '0;
    for (int g = 0; g < 3; g++) begin
      sx = dec(pdx[g]);
      sy = dec(pdy[g]);
      if (fr) begin sx = -sx; sy = -sy; end
      moved = 1'b0;
      if (sx != 0) begin
        c = mx[g] + sx;
        if (c >= 0 && c <= MAXT) begin
          ep_x[exp_np] = c; ep_y[exp_np] = my[g]; exp_np++;
          if (!wall[c][my[g]]) begin mx[g] = c; moved = 1'b1; end
        end
      end
      if (!moved && sy != 0) begin
        c = my[g] + sy;
        if (c >= 0 && c <= MAXT) begin
          ep_x[exp_np] = mx[g]; ep_y[exp_np] = c; exp_np++;
          if (!wall[mx[g]][c]) my[g] = c;
        end
      end
      if (mx[g] == pxs && my[g] == pys) exp_hit[g] = 1'b1;
    end
  endtask

  task automatic pulse_tick();
    @(negedge clk); tick = 1'b1;
    @(negedge clk); tick = 1'b0;
  endtask

  task automatic wait_done(input int target);
    int n = 0;
    while (done_cnt < target && n < 400) begin @(negedge clk); n++; end
    check("round_done_seen", 32'(done_cnt >= target), 1);
  endtask

  task automatic check_positions(input string tag);
    for (int g = 0; g < 3; g++) begin
      check($sformatf("%s_g%0d_x", tag, g), gpos(g, 1'b0), mx[g]);
      check($sformatf("%s_g%0d_y", tag, g), gpos(g, 1'b1), my[g]);
    end
  endtask

  task automatic do_reset();
    @(negedge clk); reset_n = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    mx = '{10, 9, 11};
    my = '{9, 10, 10};
  endtask

  task automatic clear_env();
    for (int x = 0; x <= MAXT; x++) for (int y = 0; y <= MAXT; y++) wall[x][y] = 1'b0;
    for (int g = 0; g < 3; g++) begin pdx[g] = 2'b00; pdy[g] = 2'b00; end
  endtask

  task automatic run_round(input string tag, input bit fr, input int pxs, input int pys);
    int sgx [3];
    int sgy [3];
    int pc0, d0, cexp;
    for (int g = 0; g < 3; g++) begin sgx[g] = mx[g]; sgy[g] = my[g]; end
    model_round(fr, pxs, pys);
    frightened = fr;
    pacman_x   = 9'(pxs);
    pacman_y   = 9'(pys);
    pc0 = pcount;
    d0  = done_cnt;
    pulse_tick();
    wait_done(d0 + 1);
    @(negedge clk);
    check({tag, "_busy_low"}, 32'(busy), 0);
    check_positions(tag);
    check({tag, "_probe_cnt"}, pcount - pc0, exp_np);
    for (int i = 0; i < exp_np; i++) begin
      check($sformatf("%s_probe%0d_x", tag, i), plog_x[(pc0 + i) % 256], ep_x[i]);
      check($sformatf("%s_probe%0d_y", tag, i), plog_y[(pc0 + i) % 256], ep_y[i]);
    end
    check({tag, "_hit"}, 32'(hit_word), 32'(exp_hit));
    for (int g = 0; g < 3; g++) begin
      if (exp_hit[g]) begin
        cexp = (g < 2) ? dreq_cyc[g + 1] - 1 : done_cyc - 1;
        check($sformatf("%s_hit_cycle_g%0d", tag, g), hit_cyc[g], cexp);
      end
      check($sformatf("%s_req_gx%0d", tag, g), 32'(seen_gx[g]), sgx[g]);
      check($sformatf("%s_req_gy%0d", tag, g), 32'(seen_gy[g]), sgy[g]);
      check($sformatf("%s_req_tx%0d", tag, g), 32'(seen_tx[g]), pxs);
      check($sformatf("%s_req_ty%0d", tag, g), 32'(seen_ty[g]), pys);
    end
  endtask

  initial begin
    int d0, n, px, py, sel;
    bit fr;
    for (int g = 0; g < 3; g++) begin dreq_cyc[g] = -100; hit_cyc[g] = -1; end
    clear_env();

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 0);
    check("rst_overrun", 32'(overrun), 0);
    check("rst_dir_req", 32'(dir_req), 0);
    check("rst_map_req", 32'(map_req), 0);
    check("rst_round_done", 32'(round_done), 0);
    check("rst_hit", 32'(hit), 0);
    check_positions("rst");
    reset_n = 1'b1;

    // Ghost 0 steps +x into an open maze
    pdx[0] = 2'b01;
    run_round("t1", 1'b0, 15, 9);

    // Frightened inverts the step; then the inverted x is walled so y moves
    do_reset(); clear_env();
    pdx[0] = 2'b01; pdy[0] = 2'b10;
    run_round("t2a", 1'b1, 15, 15);
    do_reset();
    wall[9][9] = 1'b1;
    run_round("t2b", 1'b1, 15, 15);

    // Pacman sits on ghost 1's next tile
    do_reset(); clear_env();
    pdx[1] = 2'b01;
    run_round("t4", 1'b0, 10, 10);

    // Walk ghost 2 to the right edge, then push past it with y blocked
    do_reset(); clear_env();
    pdx[2] = 2'b01;
    for (int r = 0; r < 9; r++) run_round($sformatf("t3w%0d", r), 1'b0, 0, 0);
    pdy[2] = 2'b01;
    wall[20][11] = 1'b1;
    run_round("t3", 1'b0, 0, 0);

    // Extra ticks during a round: one queued, the rest overrun
    clear_env();
    d0 = done_cnt;
    check("t5_overrun_before", 32'(overrun), 0);
    pulse_tick();
    repeat (2) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("t5_busy%0d", k), 32'(busy), 1);
      pulse_tick();
    end
    wait_done(d0 + 2);
    repeat (40) @(negedge clk);
    check("t5_round_count", done_cnt - d0, 2);
    check("t5_overrun", 32'(overrun), 1);
    check_positions("t5");

    // Asynchronous reset while a map lookup is outstanding
    pdx[0] = (mx[0] < MAXT) ? 2'b01 : 2'b10;
    ack_hold = 1'b1;
    pulse_tick();
    n = 0;
    while (!map_req && n < 60) begin @(negedge clk); n++; end
    check("t6_map_req_seen", 32'(map_req), 1);
    repeat (3) @(negedge clk);
    check("t6_map_req_held", 32'(map_req), 1);
    check("t6_overrun_pre", 32'(overrun), 1);
    #2 reset_n = 1'b0;
    #1;
    mx = '{10, 9, 11};
    my = '{9, 10, 10};
    check("t6_map_req_drop", 32'(map_req), 0);
    check("t6_busy", 32'(busy), 0);
    check("t6_overrun_clr", 32'(overrun), 0);
    check_positions("t6");
    @(negedge clk);
    ack_hold = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    run_round("t6_after", 1'b0, 3, 3);

    // Randomised rounds against the model
    for (int r = 0; r < 40; r++) begin
      for (int x = 0; x <= MAXT; x++)
        for (int y = 0; y <= MAXT; y++) wall[x][y] = ($urandom_range(0, 3) == 0);
      for (int g = 0; g < 3; g++) begin pdx[g] = 2'($urandom); pdy[g] = 2'($urandom); end
      fr = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 1) == 1) begin
        sel = $urandom_range(0, 2);
        px  = mx[sel] + 1;
        py  = my[sel];
      end else begin
        px = $urandom_range(0, MAXT);
        py = $urandom_range(0, MAXT);
      end
      run_round($sformatf("rnd%0d", r), fr, px, py);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule : tb_ghost_move_scheduler
`default_nettype wire
